// File: rtl/string_hw_multi_pkg.sv
// string_hw_pkg: shared types, constants and helpers for the string.h
// accelerator (string_hw_multi) and its iterative matcher.
//   op_e       - operation select codes (7..15 are invalid ops)
//   state_e    - control FSM states, also exported for debug
//   eng_mode_e - how the matcher interprets its i/j iterator
//   get_char   - extract character k of an n-character string whose
//                character 0 sits in the most-significant byte
package string_hw_pkg;

  // Character vectors are handed to get_char zero-extended to this width.
  // This supports up to 256 characters; MAX_CHARS must stay below 256 so
  // the CMP stop index still fits its 8-bit Result field.
  localparam int CHAR_VEC_W = 2048;

  typedef enum logic [3:0] {
    CMP     = 4'd0,
    UPPER   = 4'd1,
    LOWER   = 4'd2,
    REVERSE = 4'd3,
    SEARCH  = 4'd4,
    STRLEN  = 4'd5,
    COUNT   = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EM_SEARCH = 2'd0,
    EM_CMP    = 2'd1,
    EM_STRLEN = 2'd2
  } eng_mode_e;

  localparam logic [15:0] NOT_FOUND = 16'hFFFF;
  localparam logic [7:0]  CMP_EQ    = 8'h00;
  localparam logic [7:0]  CMP_GT    = 8'h01;
  localparam logic [7:0]  CMP_LT    = 8'hFF;

  // Out-of-range positions read as NUL so callers never need a guard.
  function automatic logic [7:0] get_char(input logic [CHAR_VEC_W-1:0] vec,
                                          input int n, input int k);
    logic [7:0] c;
    c = 8'h00;
    if (k >= 0 && k < n) c = vec[(n-1-k)*8 +: 8];
    return c;
  endfunction

endpackage

// File: rtl/string_hw_multi_if.sv
// string_hw_multi_if: CPU-side bus of the string accelerator.
//   go, op, length, A, B   - request (master -> slave)
//   done, busy, error,     - status and result (slave -> master)
//   Result, state          - state is the control FSM state for debug
// Handshake (4-phase): the master raises go with op/length/A/B valid and
// holds go high until it sees done; the slave captures the request on the
// first edge it sees go in IDLE, keeps done high until go is low, and only
// then returns to IDLE. error is meaningful only while done is high.
interface string_hw_multi_if #(parameter int MAX_CHARS = 32);
  import string_hw_pkg::*;

  localparam int LEN_W = $clog2(MAX_CHARS+1);
  localparam int RES_W = MAX_CHARS*8;

  logic             go;
  logic [3:0]       op;
  logic [LEN_W-1:0] length;
  logic [RES_W-1:0] A;
  logic [RES_W-1:0] B;
  logic             done;
  logic             busy;
  logic             error;
  logic [RES_W-1:0] Result;
  state_e           state;

  modport master (output go, op, length, A, B,
                  input  done, busy, error, Result, state);
  modport slave  (input  go, op, length, A, B,
                  output done, busy, error, Result, state);
endinterface

// File: rtl/string_hw_multi_search_engine.sv
// string_search_engine: restartable i/j character iterator.
//   clk, rst_n      - clock, asynchronous active-low reset
//   start_i         - clear i and j (asserted on the capture edge)
//   step_i          - evaluate one character step this cycle
//   mode_i          - EM_SEARCH: A[i+j] vs B[j], restart i+1 on mismatch
//                     EM_CMP:    A[j] vs B[j] with i held at 0
//                     EM_STRLEN: A[j] vs NUL
//   a_i, b_i, len_i - operands (zero-extended) and clamped length
//   found_o         - operation finished with index_o valid
//   notfound_o      - SEARCH ran out of positions (index_o = NOT_FOUND)
//   gt_o, lt_o      - CMP ordering of the mismatching characters
// found_o/notfound_o are combinational during the step cycle so the
// caller can register the result on the same edge.
module string_search_engine
  import string_hw_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int LEN_W     = $clog2(MAX_CHARS+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  step_i,
  input  eng_mode_e             mode_i,
  input  logic [CHAR_VEC_W-1:0] a_i,
  input  logic [CHAR_VEC_W-1:0] b_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  found_o,
  output logic                  notfound_o,
  output logic [15:0]           index_o,
  output logic                  gt_o,
  output logic                  lt_o
);

  // One spare bit: i reaches MAX_CHARS-L+1 when the not-found test fires.
  localparam int IW = LEN_W + 1;

  logic [IW-1:0] i_q, i_d, j_q, j_d;

  always_comb begin
    int ii, jj, ll;
    logic [7:0] ca, cb;
    ii = int'(i_q);
    jj = int'(j_q);
    ll = int'(len_i);
    ca = get_char(a_i, MAX_CHARS, ii + jj);
    cb = (mode_i == EM_STRLEN) ? 8'h00 : get_char(b_i, MAX_CHARS, jj);
    i_d        = i_q;
    j_d        = j_q;
    found_o    = 1'b0;
    notfound_o = 1'b0;
    index_o    = 16'h0000;
    gt_o       = 1'b0;
    lt_o       = 1'b0;
    if (start_i) begin
      i_d = '0;
      j_d = '0;
    end else if (step_i) begin
      case (mode_i)
        EM_SEARCH: begin
          if (ll == 0) begin
            found_o = 1'b1;
          end else if (ii + ll > MAX_CHARS) begin
            notfound_o = 1'b1;
            index_o    = NOT_FOUND;
          end else if (ca == cb) begin
            if (jj == ll - 1) begin
              found_o = 1'b1;
              index_o = 16'(ii);
            end else begin
              j_d = j_q + 1'b1;
            end
          end else begin
            // Full restart at the next start position.
            i_d = i_q + 1'b1;
            j_d = '0;
          end
        end
        EM_CMP: begin
          if (ll == 0) begin
            found_o = 1'b1;
          end else if (ca != cb) begin
            found_o = 1'b1;
            index_o = 16'(jj);
            gt_o    = (ca > cb);
            lt_o    = (ca < cb);
          end else if (ca == 8'h00) begin
            // NUL in both strings ends the compare as equal.
            found_o = 1'b1;
            index_o = 16'(jj);
          end else if (jj == ll - 1) begin
            found_o = 1'b1;
            index_o = 16'(jj + 1);
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        EM_STRLEN: begin
          if (ca == 8'h00) begin
            found_o = 1'b1;
            index_o = 16'(jj);
          end else if (jj == MAX_CHARS - 1) begin
            found_o = 1'b1;
            index_o = 16'(MAX_CHARS);
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        default: begin
          notfound_o = 1'b1;
          index_o    = NOT_FOUND;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/string_hw_multi.sv
// string_hw_multi: parametrised string.h accelerator (Nios II peripheral).
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - string_hw_multi_if slave: go/op/length/A/B in,
//           done/busy/error/Result/state out
// Single-cycle ops (UPPER, LOWER, REVERSE, COUNT, invalid) go through
// EXEC; CMP, SEARCH and STRLEN step through ITER using the shared
// string_search_engine. All operands are captured at go.
module string_hw_multi
  import string_hw_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int LEN_W     = $clog2(MAX_CHARS+1),
  parameter int RES_W     = MAX_CHARS*8
) (
  input  logic            clk,
  input  logic            reset,
  string_hw_multi_if.slave bus
);

  localparam int PAD_W = CHAR_VEC_W - RES_W;

  state_e           state_q, state_d;
  logic [RES_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]       op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d, len_clamped;
  logic             done_q, done_d, busy_q, busy_d, error_q, error_d;

  logic [CHAR_VEC_W-1:0] a_ext, b_ext;
  logic [RES_W-1:0]      exec_res, iter_res;
  logic                  exec_err;
  logic                  eng_start, eng_step, eng_found, eng_notfound;
  logic                  eng_gt, eng_lt;
  logic [15:0]           eng_index;
  eng_mode_e             eng_mode;

  assign a_ext = {{PAD_W{1'b0}}, a_q};
  assign b_ext = {{PAD_W{1'b0}}, b_q};

  assign len_clamped = (bus.length > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS)
                                                         : bus.length;

  assign eng_mode = (op_q == CMP)    ? EM_CMP :
                    (op_q == STRLEN) ? EM_STRLEN : EM_SEARCH;

  string_search_engine #(.MAX_CHARS(MAX_CHARS), .LEN_W(LEN_W)) u_engine (
    .clk        (clk),
    .rst_n      (reset),
    .start_i    (eng_start),
    .step_i     (eng_step),
    .mode_i     (eng_mode),
    .a_i        (a_ext),
    .b_i        (b_ext),
    .len_i      (len_q),
    .found_o    (eng_found),
    .notfound_o (eng_notfound),
    .index_o    (eng_index),
    .gt_o       (eng_gt),
    .lt_o       (eng_lt)
  );

  // Single-cycle operations, evaluated from the captured operands.
  always_comb begin
    logic [RES_W-1:0] up_res, lo_res, rev_res;
    logic [15:0]      cnt;
    logic [7:0]       c, key;
    int               ll;
    up_res  = '0;
    lo_res  = '0;
    rev_res = '0;
    cnt     = 16'h0000;
    ll      = int'(len_q);
    key     = get_char(b_ext, MAX_CHARS, 0);
    for (int k = 0; k < MAX_CHARS; k++) begin
      c = get_char(a_ext, MAX_CHARS, k);
      up_res[(MAX_CHARS-1-k)*8 +: 8] = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
      lo_res[(MAX_CHARS-1-k)*8 +: 8] = (c >= 8'h41 && c <= 8'h5A) ? c + 8'd32 : c;
      rev_res[(MAX_CHARS-1-k)*8 +: 8] = (k < ll) ? get_char(a_ext, MAX_CHARS, ll-1-k) : c;
      if (k < ll && c == key) cnt = cnt + 16'd1;
    end
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      UPPER:   exec_res = up_res;
      LOWER:   exec_res = lo_res;
      REVERSE: exec_res = rev_res;
      COUNT:   exec_res = RES_W'(cnt);
      default: exec_err = 1'b1;
    endcase
  end

  always_comb begin
    iter_res = '0;
    if (op_q == CMP) begin
      iter_res[7:0]  = eng_gt ? CMP_GT : (eng_lt ? CMP_LT : CMP_EQ);
      iter_res[15:8] = eng_index[7:0];
    end else begin
      iter_res[15:0] = eng_index;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    len_d     = len_q;
    result_d  = result_q;
    done_d    = done_q;
    busy_d    = busy_q;
    error_d   = error_q;
    eng_start = 1'b0;
    eng_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          a_d       = bus.A;
          b_d       = bus.B;
          op_d      = bus.op;
          len_d     = len_clamped;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          eng_start = 1'b1;
          if (bus.op == CMP || bus.op == SEARCH || bus.op == STRLEN)
            state_d = ITER;
          else
            state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = exec_res;
        error_d  = exec_err;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = DONE;
      end
      ITER: begin
        eng_step = 1'b1;
        if (eng_found || eng_notfound) begin
          result_d = iter_res;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!bus.go) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      len_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      len_q    <= len_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.error  = error_q;
  assign bus.Result = result_q;
  assign bus.state  = state_q;

endmodule

// File: doc/string_hw_multi.md
Name: string_hw_multi

Overview:
- Parametrised next-generation string.h accelerator; Nios II custom peripheral on the DE2-115 design.
- Generalises the fixed 32-character engine in three ways: configurable MAX_CHARS, length-aware operations, and inputs latched at go.
- Adds new modes: lexicographic compare with mismatch index, strlen, and character count.
- Search is a restartable iterative matcher; uses the same 4-phase go/done handshake with the CPU.

Parameters:
- MAX_CHARS, 32, characters per operand, at least 4.
- LEN_W, $clog2(MAX_CHARS+1), width of the length port.
- RES_W, MAX_CHARS*8, Result width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  start request; held high until done is seen
- op  in  4  operation select
- length  in  LEN_W  operand length in characters; clamped to MAX_CHARS
- A  in  MAX_CHARS*8  source string; char 0 in the most-significant byte
- B  in  MAX_CHARS*8  second string / pattern / key (B char 0)
- done  out  1  result valid; held until go is low
- busy  out  1  high from go capture until done
- error  out  1  invalid op; qualified by done
- Result  out  RES_W  operation result

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; done=0, busy=0, error=0; Result=0; all internal registers=0.
- Input capture: in IDLE with go=1, A, B, op and clamped length (L) are registered at the same edge; busy=1. Later input changes are ignored until the next capture.
- States: IDLE -> EXEC (ops 1,2,3,6,invalid) or ITER (ops 0,4,5) -> DONE -> IDLE.
- EXEC: one cycle. Result and done rise at the second edge after go is sampled.
- ITER: one character step per cycle; Result and done register at the same edge.
- DONE: done=1, busy=0. Go to IDLE when go=0. If go is already low on entry, done is high for exactly one cycle.
- Result fields not listed below are 0.
- op0 CMP, iterative over k=0..L-1, stopping at the first mismatch or at a NUL in both strings.
  - Result[7:0]: 8'h00 equal, 8'h01 A>B, 8'hFF A<B (unsigned char compare).
  - Result[15:8] = stop index.
  - L=0: equal, index 0, done after one ITER cycle.
- op1 UPPER: chars 'a'..'z' minus 32, all other chars unchanged, full MAX_CHARS width.
- op2 LOWER: chars 'A'..'Z' plus 32, all other chars unchanged, full MAX_CHARS width.
- op3 REVERSE: Result char k = A char L-1-k for k<L; chars k>=L copied unchanged from A. L=0 gives Result=A.
- op4 SEARCH: first position i where A[i..i+L-1]==B[0..L-1].
  - Each cycle compares A[i+j] with B[j].
  - Match with j=L-1: found at i. Match otherwise: j++. Mismatch: i++, j=0 (full restart, no skipped positions).
  - i+L > MAX_CHARS: not found.
  - Result[15:0] = i, or 16'hFFFF if not found.
  - L=0: found at 0.
  - Worst case (MAX_CHARS-L+1)*L cycles.
- op5 STRLEN: scans A one char per cycle. Result[15:0] = index of the first NUL, or MAX_CHARS if there is none. Ignores length.
- op6 COUNT: Result[15:0] = number of k<L where A char k == B char 0.
- op7..15: error=1, Result=0, one-cycle EXEC.
- go dropped mid-operation: the operation completes, DONE is entered, then IDLE per the rule above.
- Width rules: all indices and counts are zero-extended into Result. Arithmetic on chars is 8-bit and never wraps because the range check precedes it.

Decomposition:
- Package string_hw_pkg holds:
  - op_e enum: CMP, UPPER, LOWER, REVERSE, SEARCH, STRLEN, COUNT.
  - state_e enum: IDLE, EXEC, ITER, DONE.
  - Constants NOT_FOUND=16'hFFFF, CMP_EQ, CMP_GT, CMP_LT.
  - A char-extraction function.
- One sub-module, string_search_engine: the i/j iterator with start/found/notfound/index outputs. Reused by CMP (fixed i=0) and STRLEN (compare against NUL).

Test Plan:
- UPPER, A="Hello, World!" padded with NUL -> Result="HELLO, WORLD!" unchanged tail; done high 2 cycles after go; error=0.
- CMP, A="apple", B="apply", L=5 -> Result[7:0]=8'hFF, Result[15:8]=4. With A=B, L=5 -> 8'h00, index 5.
- SEARCH, A="aaab...", B="aab", L=3 -> Result=1, which proves the restart.
  - B="xyz" -> 16'hFFFF after (MAX_CHARS-2)*1 + extra steps.
  - L=0 -> Result=0.
- REVERSE, A="abcdef", L=4 -> "dcba" then "ef" unchanged. STRLEN on "abcdef" -> 6. STRLEN on all non-NUL -> MAX_CHARS.
- op=9 -> error=1, done=1, Result=0. Hold go high 5 cycles -> done held; drop go -> IDLE next cycle.
- reset low mid-SEARCH -> done=0, busy=0, Result=0 immediately (asynchronous); a new go after release runs cleanly. Change A after capture -> Result unaffected.
